// File: rtl/soric_cfg_pkg.sv
// Purpose: shared constants for the Wishbone config frame loader (register map, CTRL bits, FSM states).
// Latency: n/a, declarations only.
// Backpressure: n/a.
package soric_cfg_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    // Register index taken from adr[3:2]; adr[1:0] is not decoded.
    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_STAT  = 2'd1;
    localparam logic [1:0] REG_DATA  = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_ACK   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with push/pop/flush and full/empty/level flags.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/wb_cfg_frame_loader.sv
// Purpose: Wishbone slave buffering eFPGA config words and streaming them to the frame shifter.
// Latency: ack one cycle after a decoded strobe (2-cycle access); pushed word reaches cfg_data_o next cycle.
// Backpressure: DATA writes to a full FIFO stall the bus; cfg_ready_i low holds the stream head.
module wb_cfg_frame_loader
    import soric_cfg_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cfg_data_o,
    output logic        cfg_valid_o,
    input  logic        cfg_ready_i,
    output logic        irq_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    wb_state_t   state;
    logic        enable;
    logic        irq_en;
    logic [31:0] count;

    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [31:0]   fifo_head;

    logic        req;
    logic        hit;
    logic [1:0]  reg_idx;
    logic        is_data_wr;
    logic        wr_fire;
    logic        stall_go;
    logic        push;
    logic        flush;
    logic        pop;
    logic        ctrl_wr;
    logic        count_wr;
    logic [31:0] rdata;
    logic        unused_adr_lsb;

    assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign hit        = req & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_idx    = wbs_adr_i[3:2];
    assign is_data_wr = wbs_we_i & (reg_idx == REG_DATA);

    // Register side effects fire on the IDLE->ACK edge; stalled DATA writes push on STALL->ACK.
    assign wr_fire  = (state == ST_IDLE) & hit & wbs_we_i & ~(is_data_wr & fifo_full);
    assign stall_go = (state == ST_STALL) & req & ~fifo_full;
    assign push     = ((wr_fire & is_data_wr) | stall_go) & (wbs_sel_i == 4'hF);
    assign ctrl_wr  = wr_fire & (reg_idx == REG_CTRL) & wbs_sel_i[0];
    assign flush    = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
    assign count_wr = wr_fire & (reg_idx == REG_COUNT);

    assign cfg_valid_o = enable & ~fifo_empty;
    assign cfg_data_o  = fifo_head;
    assign pop         = cfg_valid_o & cfg_ready_i;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .push     (push),
        .push_dat (wbs_dat_i),
        .pop      (pop),
        .flush    (flush),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Read mux; flush always reads back as zero, DATA is write-only.
    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:  rdata = {29'd0, irq_en, 1'b0, enable};
            REG_STAT:  rdata = {count[15:0], 8'(fifo_level), 6'd0, fifo_full, fifo_empty};
            REG_COUNT: rdata = count;
            default:   rdata = '0;
        endcase
    end

    // Bus FSM with registered ack and read data (data is zero whenever ack is low).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                    if (hit) begin
                        if (is_data_wr && fifo_full) begin
                            state <= ST_STALL;
                        end else begin
                            state     <= ST_ACK;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= wbs_we_i ? 32'd0 : rdata;
                        end
                    end
                end
                ST_STALL: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else if (!fifo_full) begin
                        state     <= ST_ACK;
                        wbs_ack_o <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state     <= ST_IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
            endcase
        end
    end

    // Control bits and handoff counter; a COUNT write wins over a same-cycle handshake.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            enable <= 1'b0;
            irq_en <= 1'b0;
            count  <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= wbs_dat_i[CTRL_EN];
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (count_wr)  count <= '0;
            else if (pop)  count <= count + 32'd1;
        end
    end

    // Done interrupt: everything handed off and the stream has gone idle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_o <= 1'b0;
        else          irq_o <= irq_en & enable & fifo_empty & (count != 32'd0);
    end

endmodule

// File: tb/tb_wb_cfg_frame_loader.sv
module tb_wb_cfg_frame_loader;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] A_CTRL  = BASE + 32'h0;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;
    localparam logic [31:0] A_DATA  = BASE + 32'h8;
    localparam logic [31:0] A_COUNT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] dat_o;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] popped[$];
    int unsigned exp_count;

    always #5 clk = ~clk;

    wb_cfg_frame_loader #(.FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .cfg_data_o  (cfg_data),
        .cfg_valid_o (cfg_valid),
        .cfg_ready_i (cfg_ready),
        .irq_o       (irq)
    );

    // Stream-side monitor: a handshake visible at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && cfg_valid && cfg_ready) popped.push_back(cfg_data);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All bus tasks assume the caller sits #1 after a rising edge, and return there.
    task automatic bus_start(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    endtask

    task automatic bus_wait(input int limit, output bit acked, output logic [31:0] rd, output int n);
        acked = 1'b0; rd = '0; n = 1;
        for (int i = 0; i < limit && !acked; i++) begin
            @(posedge clk); #1;
            n++;
            if (ack) begin acked = 1'b1; rd = dat_o; end
        end
    endtask

    task automatic bus_end();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        @(posedge clk); #1;
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [31:0] rd, output int n, output bit acked);
        bus_start(w, a, d, s);
        bus_wait(40, acked, rd, n);
        bus_end();
    endtask

    task automatic push_word(input logic [31:0] w, output int n, output bit acked);
        logic [31:0] rd;
        wb_access(1'b1, A_DATA, w, 4'hF, rd, n, acked);
        if (acked) exp_q.push_back(w);
    endtask

    task automatic test_reset();
        logic [31:0] rd; int n; bit ok;
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; cfg_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        if ({ack, dat_o, cfg_valid, cfg_data, irq} !== 67'd0) begin errors++;
            $display("FAIL reset_outputs: ack=%b dat=%h valid=%b data=%h irq=%b want all 0", ack, dat_o, cfg_valid, cfg_data, irq); end
        checks++;
        rst = 1'b0;
        @(posedge clk); #1;
        wb_access(1'b0, A_STAT, 32'd0, 4'hF, rd, n, ok);
        if (!ok || rd !== 32'h0000_0001) begin errors++; $display("FAIL reset_stat: acked=%b got %h want 00000001", ok, rd); end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL ack_latency: got %0d cycles want 2", n); end
        checks++;
        wb_access(1'b0, A_CTRL, 32'd0, 4'hF, rd, n, ok);
        if (!ok || rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", rd); end
        checks++;
        wb_access(1'b0, A_COUNT, 32'd0, 4'hF, rd, n, ok);
        if (!ok || rd !== 32'd0) begin errors++; $display("FAIL reset_count: got %h want 0", rd); end
        checks++;
        bus_start(1'b0, BASE + 32'h10, 32'd0, 4'hF);
        bus_wait(5, ok, rd, n);
        if (ok) begin errors++; $display("FAIL addr_miss: acked=1 want no ack"); end
        checks++;
        bus_end();
        if (dat_o !== 32'd0) begin errors++; $display("FAIL idle_rdata: got %h want 0", dat_o); end
        checks++;
        // Reset with words buffered and an access in flight.
        wb_access(1'b1, A_CTRL, 32'h1, 4'hF, rd, n, ok);
        push_word($urandom, n, ok);
        push_word($urandom, n, ok);
        bus_start(1'b0, A_COUNT, 32'd0, 4'hF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (ack !== 1'b0 || cfg_valid !== 1'b0) begin errors++; $display("FAIL midreset: ack=%b valid=%b want 0 0", ack, cfg_valid); end
        checks++;
        bus_end();
        exp_q.delete(); popped.delete(); exp_count = 0;
        wb_access(1'b0, A_STAT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== 32'h0000_0001) begin errors++; $display("FAIL midreset_stat: got %h want 00000001", rd); end
        checks++;
        wb_access(1'b0, A_CTRL, 32'd0, 4'hF, rd, n, ok);
        if (rd !== 32'd0) begin errors++; $display("FAIL midreset_ctrl: got %h want 0", rd); end
        checks++;
    endtask

    task automatic test_stream();
        logic [31:0] rd; int n; bit ok; int sz;
        popped.delete(); exp_q.delete();
        cfg_ready = 1'b1;
        wb_access(1'b1, A_CTRL, 32'h1, 4'hF, rd, n, ok);
        push_word(32'hDEAD_BEEF, n, ok);
        if (!ok || n !== 2) begin errors++; $display("FAIL stream_push_ack: acked=%b cycles=%0d want 1 2", ok, n); end
        checks++;
        push_word(32'h1234_5678, n, ok);
        for (int i = 0; i < 4; i++) push_word($urandom, n, ok);
        repeat (3) @(posedge clk); #1;
        sz = exp_q.size();
        if (popped.size() !== sz) begin errors++; $display("FAIL stream_len: got %0d want %0d", popped.size(), sz); end
        checks++;
        for (int i = 0; i < sz && i < popped.size(); i++) begin
            if (popped[i] !== exp_q[i]) begin errors++; $display("FAIL stream_word%0d: got %h want %h", i, popped[i], exp_q[i]); end
            checks++;
        end
        exp_count += sz;
        wb_access(1'b0, A_COUNT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== exp_count) begin errors++; $display("FAIL stream_count: got %0d want %0d", rd, exp_count); end
        checks++;
        wb_access(1'b0, A_STAT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== {exp_count[15:0], 8'd0, 6'd0, 2'b01}) begin errors++;
            $display("FAIL stream_stat: got %h want %h", rd, {exp_count[15:0], 8'd0, 6'd0, 2'b01}); end
        checks++;
        exp_q.delete(); popped.delete();
    endtask

    task automatic test_stall();
        logic [31:0] rd, w9; int n; bit ok, all_ok;
        cfg_ready = 1'b0;
        all_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin push_word($urandom, n, ok); all_ok &= ok; end
        if (!all_ok) begin errors++; $display("FAIL stall_fill: a fill write was not acked"); end
        checks++;
        wb_access(1'b0, A_STAT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== {exp_count[15:0], 8'd8, 6'd0, 2'b10}) begin errors++;
            $display("FAIL stall_full_stat: got %h want %h", rd, {exp_count[15:0], 8'd8, 6'd0, 2'b10}); end
        checks++;
        w9 = $urandom;
        bus_start(1'b1, A_DATA, w9, 4'hF);
        bus_wait(6, ok, rd, n);
        if (ok) begin errors++; $display("FAIL stall_noack: acked=1 want 0"); end
        checks++;
        cfg_ready = 1'b1;
        @(posedge clk); #1;
        cfg_ready = 1'b0;
        bus_wait(4, ok, rd, n);
        if (!ok) begin errors++; $display("FAIL stall_release: acked=0 want 1"); end
        checks++;
        if (ok) exp_q.push_back(w9);
        bus_end();
        wb_access(1'b0, A_STAT, 32'd0, 4'hF, rd, n, ok);
        if (rd[15:8] !== 8'd8 || rd[31:16] !== 16'(exp_count + 1)) begin errors++;
            $display("FAIL stall_level: level=%0d count=%0d want 8 %0d", rd[15:8], rd[31:16], exp_count + 1); end
        checks++;
        cfg_ready = 1'b1;
        repeat (12) @(posedge clk); #1;
        cfg_ready = 1'b0;
        if (popped.size() !== 9) begin errors++; $display("FAIL stall_drain_len: got %0d want 9", popped.size()); end
        checks++;
        for (int i = 0; i < 9 && i < popped.size() && i < exp_q.size(); i++) begin
            if (popped[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d: got %h want %h", i, popped[i], exp_q[i]); end
            checks++;
        end
        exp_count += 9;
        exp_q.delete(); popped.delete();
    endtask

    task automatic test_abort();
        logic [31:0] rd; int n; bit ok, seen;
        cfg_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word($urandom, n, ok);
        bus_start(1'b1, A_DATA, $urandom, 4'hF);
        bus_wait(4, ok, rd, n);
        seen = ok;
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; seen |= ack; end
        if (seen) begin errors++; $display("FAIL abort_noack: ack seen want none"); end
        checks++;
        bus_end();
        wb_access(1'b0, A_STAT, 32'd0, 4'hF, rd, n, ok);
        if (n !== 2 || rd !== {exp_count[15:0], 8'd8, 6'd0, 2'b10}) begin errors++;
            $display("FAIL abort_stat: cycles=%0d got %h want 2 %h", n, rd, {exp_count[15:0], 8'd8, 6'd0, 2'b10}); end
        checks++;
        cfg_ready = 1'b1;
        repeat (12) @(posedge clk); #1;
        cfg_ready = 1'b0;
        if (popped.size() !== 8) begin errors++; $display("FAIL abort_drain_len: got %0d want 8", popped.size()); end
        checks++;
        for (int i = 0; i < 8 && i < popped.size(); i++) begin
            if (popped[i] !== exp_q[i]) begin errors++; $display("FAIL abort_word%0d: got %h want %h", i, popped[i], exp_q[i]); end
            checks++;
        end
        exp_count += 8;
        exp_q.delete(); popped.delete();
    endtask

    task automatic test_flush();
        logic [31:0] rd; int n; bit ok;
        cfg_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word($urandom, n, ok);
        cfg_ready = 1'b1;
        bus_start(1'b1, A_CTRL, 32'h3, 4'hF);
        bus_wait(6, ok, rd, n);
        if (!ok || cfg_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: acked=%b valid=%b want 1 0", ok, cfg_valid); end
        checks++;
        cfg_ready = 1'b0;
        bus_end();
        if (popped.size() !== 1 || popped[0] !== exp_q[0]) begin errors++;
            $display("FAIL flush_handshake: popped %0d words first=%h want 1 word %h", popped.size(), (popped.size() > 0) ? popped[0] : 32'hx, exp_q[0]); end
        checks++;
        exp_count += 1;
        exp_q.delete(); popped.delete();
        wb_access(1'b0, A_STAT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== {exp_count[15:0], 8'd0, 6'd0, 2'b01}) begin errors++;
            $display("FAIL flush_stat: got %h want %h", rd, {exp_count[15:0], 8'd0, 6'd0, 2'b01}); end
        checks++;
        wb_access(1'b0, A_COUNT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== exp_count) begin errors++; $display("FAIL flush_count: got %0d want %0d", rd, exp_count); end
        checks++;
        wb_access(1'b0, A_CTRL, 32'd0, 4'hF, rd, n, ok);
        if (rd !== 32'h1) begin errors++; $display("FAIL flush_selfclear: got %h want 00000001", rd); end
        checks++;
    endtask

    task automatic test_irq();
        logic [31:0] rd; int n; bit ok; int t_empty, t_irq;
        cfg_ready = 1'b0;
        wb_access(1'b1, A_CTRL, 32'h5, 4'hF, rd, n, ok);
        wb_access(1'b1, A_COUNT, 32'hFFFF_FFFF, 4'h1, rd, n, ok);
        exp_count = 0;
        for (int i = 0; i < 3; i++) push_word($urandom, n, ok);
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
        checks++;
        cfg_ready = 1'b1;
        t_empty = -1; t_irq = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (t_empty < 0 && !cfg_valid) t_empty = c;
            if (t_irq < 0 && irq) t_irq = c;
        end
        if (t_empty < 0 || t_irq !== t_empty + 1) begin errors++;
            $display("FAIL irq_rise: irq at %0d empty at %0d want irq one cycle after empty", t_irq, t_empty); end
        checks++;
        exp_count += 3;
        if (popped.size() !== 3 || popped[0] !== exp_q[0] || popped[2] !== exp_q[2]) begin errors++;
            $display("FAIL irq_drain: popped %0d words want 3 in order", popped.size()); end
        checks++;
        exp_q.delete(); popped.delete();
        wb_access(1'b0, A_COUNT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== exp_count) begin errors++; $display("FAIL irq_count: got %0d want %0d", rd, exp_count); end
        checks++;
        wb_access(1'b1, A_COUNT, 32'h0, 4'hF, rd, n, ok);
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq); end
        checks++;
        exp_count = 0;
        wb_access(1'b0, A_COUNT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== 32'd0) begin errors++; $display("FAIL count_clear: got %0d want 0", rd); end
        checks++;
        cfg_ready = 1'b0;
        wb_access(1'b1, A_DATA, $urandom, 4'h3, rd, n, ok);
        if (!ok || n !== 2) begin errors++; $display("FAIL partial_sel_ack: acked=%b cycles=%0d want 1 2", ok, n); end
        checks++;
        wb_access(1'b0, A_STAT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== 32'h0000_0001) begin errors++; $display("FAIL partial_sel_level: got %h want 00000001", rd); end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int n; bit ok, all_ok; int min_n;
        wb_access(1'b1, A_CTRL, 32'h1, 4'hF, rd, n, ok);
        all_ok = 1'b1; min_n = 100;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    @(posedge clk); #1;
                    cfg_ready = 1'($urandom_range(0, 1));
                end
                cfg_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    push_word($urandom, n, ok);
                    all_ok &= ok;
                    if (n < min_n) min_n = n;
                end
            end
        join
        if (!all_ok || min_n < 2) begin errors++; $display("FAIL b2b_acks: all_acked=%b min_cycles=%0d want 1 >=2", all_ok, min_n); end
        checks++;
        repeat (12) @(posedge clk); #1;
        if (popped.size() !== 20) begin errors++; $display("FAIL b2b_len: got %0d want 20", popped.size()); end
        checks++;
        for (int i = 0; i < 20 && i < popped.size(); i++) begin
            if (popped[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, popped[i], exp_q[i]); end
            checks++;
        end
        exp_count += 20;
        wb_access(1'b0, A_COUNT, 32'd0, 4'hF, rd, n, ok);
        if (rd !== exp_count) begin errors++; $display("FAIL b2b_count: got %0d want %0d", rd, exp_count); end
        checks++;
        exp_q.delete(); popped.delete();
    endtask

    initial begin
        exp_count = 0;
        test_reset();
        test_stream();
        test_stall();
        test_abort();
        test_flush();
        test_irq();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
